// File: rtl/cmd_sequencer.sv
// Host-command sequencer: accepts one 16-bit command at a time, dispatches EXEC ops and returns one response byte.
// Optional execution timeout is enabled by defining CMD_TIMEOUT_EN.
module cmd_sequencer #(
  parameter logic [7:0] ACK       = 8'hA5,
  parameter logic [7:0] NAK       = 8'hEE,
  parameter logic [7:0] TO_RESP   = 8'hE7,
  parameter int         TO_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_rdy,
  input  logic [15:0] cmd,
  output logic        clr_cmd_rdy,
  output logic        trmt,
  output logic [7:0]  resp,
  input  logic        tx_done,
  output logic        exe_strt,
  output logic [2:0]  exe_op,
  output logic [11:0] exe_arg,
  input  logic        exe_done,
  output logic        exe_abort,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, DECODE, WAIT_EXE, SEND, WAIT_TX} state_t;

  state_t      state, state_next;
  logic [15:0] cmd_q, cmd_q_next;
  logic [7:0]  resp_next;
  logic [2:0]  exe_op_next;
  logic [11:0] exe_arg_next;
  logic [3:0]  err_cnt, err_cnt_next;
  logic [3:0]  last_op, last_op_next;
  logic        clr_next, trmt_next, strt_next, abort_next, busy_next;
  logic [3:0]  opcode;
  logic [3:0]  err_inc;

  assign opcode  = cmd_q[15:12];
  assign err_inc = (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;

`ifdef CMD_TIMEOUT_EN
  logic [31:0] to_cnt, to_cnt_next;
`endif

  always_comb begin
    state_next   = state;
    cmd_q_next   = cmd_q;
    resp_next    = resp;
    exe_op_next  = exe_op;
    exe_arg_next = exe_arg;
    err_cnt_next = err_cnt;
    last_op_next = last_op;
    clr_next     = 1'b0;
    trmt_next    = 1'b0;
    strt_next    = 1'b0;
    abort_next   = 1'b0;
`ifdef CMD_TIMEOUT_EN
    to_cnt_next  = to_cnt;
`endif
    case (state)
      IDLE: begin
        if (cmd_rdy) begin
          cmd_q_next = cmd;
          clr_next   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (opcode == 4'h0) begin
          resp_next    = ACK;
          last_op_next = opcode;
          state_next   = SEND;
        end else if (opcode <= 4'h7) begin
          exe_op_next  = cmd_q[14:12];
          exe_arg_next = cmd_q[11:0];
          strt_next    = 1'b1;
          last_op_next = opcode;
          state_next   = WAIT_EXE;
`ifdef CMD_TIMEOUT_EN
          to_cnt_next  = 32'd0;
`endif
        end else if (opcode == 4'h8) begin
          // STATUS reports last_op as it stood before this command
          resp_next    = {err_cnt, last_op};
          last_op_next = opcode;
          state_next   = SEND;
        end else begin
          resp_next    = NAK;
          err_cnt_next = err_inc;
          state_next   = SEND;
        end
      end
      WAIT_EXE: begin
        if (exe_done) begin
          resp_next  = ACK;
          state_next = SEND;
        end
`ifdef CMD_TIMEOUT_EN
        else if (to_cnt == 32'(TO_CYCLES - 1)) begin
          abort_next   = 1'b1;
          resp_next    = TO_RESP;
          err_cnt_next = err_inc;
          state_next   = SEND;
        end else begin
          to_cnt_next = to_cnt + 32'd1;
        end
`endif
      end
      SEND: begin
        trmt_next  = 1'b1;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_q       <= 16'h0000;
      resp        <= 8'h00;
      exe_op      <= 3'd0;
      exe_arg     <= 12'h000;
      err_cnt     <= 4'h0;
      last_op     <= 4'h0;
      clr_cmd_rdy <= 1'b0;
      trmt        <= 1'b0;
      exe_strt    <= 1'b0;
      exe_abort   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cmd_q       <= cmd_q_next;
      resp        <= resp_next;
      exe_op      <= exe_op_next;
      exe_arg     <= exe_arg_next;
      err_cnt     <= err_cnt_next;
      last_op     <= last_op_next;
      clr_cmd_rdy <= clr_next;
      trmt        <= trmt_next;
      exe_strt    <= strt_next;
      exe_abort   <= abort_next;
      busy        <= busy_next;
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt <= 32'd0;
    else     to_cnt <= to_cnt_next;
  end
`endif

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer; define CMD_TIMEOUT_EN to also exercise the timeout path with TO_CYCLES=100.
module tb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_rdy = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done = 1'b0;
  logic        exe_strt;
  logic [2:0]  exe_op;
  logic [11:0] exe_arg;
  logic        exe_done = 1'b0;
  logic        exe_abort;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int tcount = 0;
  int tsnap;

  always #5 clk = ~clk;

  cmd_sequencer #(.TO_CYCLES(100)) dut (
      .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd),
      .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt), .resp(resp), .tx_done(tx_done),
      .exe_strt(exe_strt), .exe_op(exe_op), .exe_arg(exe_arg),
      .exe_done(exe_done), .exe_abort(exe_abort), .busy(busy)
  );

  always @(negedge clk) if (trmt) tcount++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Non-EXEC command: clr at +1, trmt at +3, busy until tx_done
  task automatic send_simple(input logic [15:0] c, input logic [7:0] exp, input string tag);
    cmd = c; cmd_rdy = 1'b1;
    tick();
    chk({tag, "_clr"}, 32'(clr_cmd_rdy), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    cmd_rdy = 1'b0;
    tick();
    chk({tag, "_clr_off"}, 32'(clr_cmd_rdy), 32'd0);
    chk({tag, "_trmt_early"}, 32'(trmt), 32'd0);
    tick();
    chk({tag, "_trmt"}, 32'(trmt), 32'd1);
    chk({tag, "_resp"}, 32'(resp), 32'(exp));
    tick();
    chk({tag, "_trmt_off"}, 32'(trmt), 32'd0);
    chk({tag, "_resp_hold"}, 32'(resp), 32'(exp));
    chk({tag, "_busy_tx"}, 32'(busy), 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    $display("cmd=%h resp=%h", c, resp);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp", 32'(resp), 32'h00);
    chk("rst_trmt", 32'(trmt), 32'd0);
    chk("rst_exe_op", 32'(exe_op), 32'd0);
    chk("rst_exe_arg", 32'(exe_arg), 32'd0);
    rst = 1'b0;
    tick();

    send_simple(16'h0123, 8'hA5, "nop");
    send_simple(16'hF000, 8'hEE, "illegal");
    send_simple(16'h8000, 8'h10, "status1");

    // EXEC 3/ABC with exe_done 50 clocks after start
    cmd = 16'h3ABC; cmd_rdy = 1'b1;
    tick();
    chk("exec_clr", 32'(clr_cmd_rdy), 32'd1);
    cmd_rdy = 1'b0;
    tick();
    chk("exec_strt", 32'(exe_strt), 32'd1);
    chk("exec_op", 32'(exe_op), 32'd3);
    chk("exec_arg", 32'(exe_arg), 32'hABC);
    tick();
    chk("exec_strt_off", 32'(exe_strt), 32'd0);
    repeat (48) tick();
    chk("exec_op_hold", 32'(exe_op), 32'd3);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_no_trmt", 32'(trmt), 32'd0);
    exe_done = 1'b1;
    tick();
    exe_done = 1'b0;
    chk("exec_trmt_early", 32'(trmt), 32'd0);
    tick();
    chk("exec_trmt", 32'(trmt), 32'd1);
    chk("exec_resp", 32'(resp), 32'hA5);
    chk("exec_abort", 32'(exe_abort), 32'd0);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("exec_idle", 32'(busy), 32'd0);
    $display("cmd=3abc resp=%h", resp);

    send_simple(16'h8000, 8'h13, "status2");

    // Back-to-back: second command raised during WAIT_TX
    tsnap = tcount;
    cmd = 16'h0001; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    tick();
    tick();
    chk("b2b_trmt1", 32'(trmt), 32'd1);
    cmd = 16'h0002; cmd_rdy = 1'b1;
    tick();
    chk("b2b_held", 32'(clr_cmd_rdy), 32'd0);
    tick();
    chk("b2b_held2", 32'(clr_cmd_rdy), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("b2b_idle", 32'(busy), 32'd0);
    chk("b2b_not_yet", 32'(clr_cmd_rdy), 32'd0);
    tick();
    chk("b2b_clr", 32'(clr_cmd_rdy), 32'd1);
    cmd_rdy = 1'b0;
    tick();
    tick();
    chk("b2b_trmt2", 32'(trmt), 32'd1);
    chk("b2b_resp2", 32'(resp), 32'hA5);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    chk("b2b_count", 32'(tcount - tsnap), 32'd2);
    $display("b2b cmds=0001,0002 trmt_pulses=%0d", tcount - tsnap);

    // exe_done outside WAIT_EXE must be ignored
    exe_done = 1'b1;
    tick();
    exe_done = 1'b0;
    tick();
    chk("stray_done_busy", 32'(busy), 32'd0);
    chk("stray_done_trmt", 32'(trmt), 32'd0);

    // Reset while in WAIT_EXE
    tsnap = tcount;
    cmd = 16'h1005; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    tick();
    tick();
    tick();
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_exe_op", 32'(exe_op), 32'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rstmid_no_trmt", 32'(tcount - tsnap), 32'd0);
    $display("reset during cmd=1005 busy=%0d", busy);
    send_simple(16'h0000, 8'hA5, "nop_after_rst");
    send_simple(16'h8000, 8'h00, "status_after_rst");

`ifdef CMD_TIMEOUT_EN
    cmd = 16'h2000; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    tick();
    chk("to_strt", 32'(exe_strt), 32'd1);
    repeat (99) tick();
    chk("to_abort_early", 32'(exe_abort), 32'd0);
    tick();
    chk("to_abort", 32'(exe_abort), 32'd1);
    chk("to_resp", 32'(resp), 32'hE7);
    tick();
    chk("to_abort_off", 32'(exe_abort), 32'd0);
    chk("to_trmt", 32'(trmt), 32'd1);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    $display("cmd=2000 timeout resp=%h", resp);
    send_simple(16'h8000, 8'h12, "status_after_to");
`else
    chk("abort_tied", 32'(exe_abort), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
